rvh_l1d_ld_resp_fmt: RTL and testbench
======================================

// Module: rvh_l1d_ld_resp_fmt
// PURPOSE
// Return-path end of the L1D load/store request interface: takes the decoded request type
// (rrv64_l1d_req_type_dec_t) and the raw 64-bit data word, extracts, zero/sign-extends and
// queues the architectural result toward the LSU/PTW. Sits after the data-RAM read/AMO stage.
// Buffers results in a small FIFO with valid/ready back-pressure.
// PARAMETERS
// XLEN        64  data width; fixed 64, byte offset is 3 bits
// ROB_TAG_W   7   ROB tag width carried with each response
// LDQ_TAG_W   5   load-queue tag width carried with each response
// DEPTH       2   response FIFO entries, power of two, >=2
// PORTS
// clk            in   1          clock
// rst            in   1          asynchronous active-low reset
// flush_i        in   1          synchronous flush of all queued responses
// req_vld_i      in   1          request valid
// req_rdy_o      out  1          request ready
// req_type_i     in   struct     rrv64_l1d_req_type_dec_t (is_ld/is_ptw_ld/is_st/is_lr/is_sc/is_amo, op_*, ld_u)
// req_data_i     in   XLEN       raw 8-byte-aligned word (RAM data or AMO old value)
// req_offset_i   in   3          byte offset of access inside the word
// req_sc_fail_i  in   1          SC failed (reservation lost); valid when is_sc
// req_rob_tag_i  in   ROB_TAG_W  ROB tag
// req_ldq_tag_i  in   LDQ_TAG_W  load-queue tag
// resp_vld_o     out  1          response valid (head of FIFO)
// resp_rdy_i     in   1          consumer ready
// resp_data_o    out  XLEN       formatted result
// resp_rob_tag_o out  ROB_TAG_W  ROB tag of head
// resp_ldq_tag_o out  LDQ_TAG_W  load-queue tag of head
// resp_is_ptw_o  out  1          head is a PTW load (route to PTW, not ROB)
// resp_misalign_o out 1          head access misaligned; resp_data_o = 0
// BEHAVIOUR
// - Reset (rst=0): FIFO empty, resp_vld_o=0, resp_data_o/tags/flags=0, req_rdy_o=1 after release.
// - Accept = req_vld_i & req_rdy_o. Pop = resp_vld_o & resp_rdy_i.
// - req_rdy_o = !full | pop (enqueue into slot freed same cycle when full). No empty bypass:
//   fixed 1-cycle min latency, accept in cycle N -> resp_vld_o in N+1.
// - Enqueue classes: is_ld, is_ptw_ld, is_lr, is_sc, is_amo. Pure is_st, or all-zero type:
//   accepted (rdy honoured) and silently dropped, no FIFO write.
// - Size fields are one-hot by contract; if violated, priority dw > w > hw > b.
// - Extract: b: data[off*8+:8]; hw: data[off[2:1]*16+:16]; w: data[off[2]*32+:32]; dw: data.
// - Extend: zero if ld_u else sign. LR/AMO/SC W-ops always sign-extended. is_ptw_ld = dw.
// - SC: resp_data_o = {63'b0, req_sc_fail_i} (0 = success), regardless of req_data_i.
// - Misalign: hw & off[0], w & |off[1:0], dw & |off[2:0] -> misalign=1, data=0.
// - Pointers wrap modulo DEPTH; full/empty via extra pointer bit or count, both >=0 && <=DEPTH.
// - Simultaneous accept+pop on full or non-empty FIFO: count unchanged, order preserved.
// - flush_i: FIFO emptied next cycle; a request accepted in the flush cycle is discarded;
//   resp_vld_o=0 the cycle after. Flush dominates push and pop.
// - Reset mid-operation: all entries lost, outputs to reset values immediately (async).
// - Outputs come straight from FIFO head registers; no combinational path req_* -> resp_*.
// STRUCTURE
// - rvh_l1d_pkg: rrv64_l1d_resp_entry_t {data, rob_tag, ldq_tag, is_ptw, misalign};
//   function rrv64_l1d_ld_fmt(type, data, offset) shared with future forward-path users.
// - Sub-module rvh_l1d_resp_fifo: generic DEPTH-entry valid/ready FIFO of entry_t with flush.
// - Top: combinational formatter + enqueue-class filter feeding the FIFO.
// TESTING
// - LB off=3, data=0x0000_0000_80FF_0000 byte=0x80? use data[31:24]=0x80 -> resp 0xFFFF_FFFF_FFFF_FF80; LBU -> 0x80.
// - LW off=4, data=0x8000_0001_xxxx_xxxx -> 0xFFFF_FFFF_8000_0001; LWU -> 0x0000_0000_8000_0001.
// - SC.D sc_fail=1 -> data=1; sc_fail=0 -> data=0; LH off=1 -> misalign=1, data=0.
// - SD (pure store) accepted with rdy=1 -> no resp_vld_o; FIFO count unchanged.
// - resp_rdy_i=0 for 3 LDs: 2 queued, req_rdy_o=0 on third; then rdy=1 -> pop+push same cycle,
//   responses emerge in order with correct rob/ldq tags, no loss or duplication.
// - FIFO full + flush_i with concurrent accept -> resp_vld_o=0 next cycle; async rst mid-stream -> all outputs 0.

Source files
------------

// File: rtl/rvh_l1d_pkg.sv
// L1D shared types: decoded request type, response entry
// and the load-result formatter reused by forwarding paths.
package rvh_l1d_pkg;

  localparam int XLEN      = 64;
  localparam int ROB_TAG_W = 7;
  localparam int LDQ_TAG_W = 5;

  typedef struct packed {
    logic is_ld;
    logic is_ptw_ld;
    logic is_st;
    logic is_lr;
    logic is_sc;
    logic is_amo;
    logic op_b;
    logic op_hw;
    logic op_w;
    logic op_dw;
    logic ld_u;
  } rrv64_l1d_req_type_dec_t;

  typedef struct packed {
    logic [XLEN-1:0]      data;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [LDQ_TAG_W-1:0] ldq_tag;
    logic                 is_ptw;
    logic                 misalign;
  } rrv64_l1d_resp_entry_t;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            misalign;
  } rrv64_l1d_fmt_t;

  function automatic rrv64_l1d_fmt_t rrv64_l1d_ld_fmt(
    input rrv64_l1d_req_type_dec_t t,
    input logic [XLEN-1:0]         d,
    input logic [2:0]              off
  );
    rrv64_l1d_fmt_t r;
    logic           sx;
    logic [7:0]     b;
    logic [15:0]    h;
    logic [31:0]    w;
    r  = '0;
    // LR/SC/AMO results are architecturally signed
    sx = ~t.ld_u | t.is_lr | t.is_amo | t.is_sc;
    b  = d[{off, 3'b000} +: 8];
    h  = d[{off[2:1], 4'b0000} +: 16];
    w  = d[{off[2], 5'b00000} +: 32];
    case (1'b1)
      t.op_dw | t.is_ptw_ld: begin
        r.misalign = |off;
        r.data     = d;
      end
      t.op_w: begin
        r.misalign = |off[1:0];
        r.data     = {{32{sx & w[31]}}, w};
      end
      t.op_hw: begin
        r.misalign = off[0];
        r.data     = {{48{sx & h[15]}}, h};
      end
      t.op_b: begin
        r.misalign = 1'b0;
        r.data     = {{56{sx & b[7]}}, b};
      end
      default: begin
        r.misalign = |off;
        r.data     = d;
      end
    endcase
    if (r.misalign) r.data = '0;
    return r;
  endfunction

endpackage

// File: rtl/rvh_l1d_resp_fifo.sv
// Small valid/ready FIFO of response entries with
// synchronous flush; head drives outputs directly.
module rvh_l1d_resp_fifo
  import rvh_l1d_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push_vld,
  output logic                  push_rdy,
  input  rrv64_l1d_resp_entry_t push_data,
  output logic                  pop_vld,
  input  logic                  pop_rdy,
  output rrv64_l1d_resp_entry_t pop_data
);

  localparam int AW = $clog2(DEPTH);

  rrv64_l1d_resp_entry_t mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pop      = pop_vld & pop_rdy;
  assign push_rdy = ~full | pop;
  assign push     = push_vld & push_rdy;

  assign pop_vld  = ~empty;
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rvh_l1d_ld_resp_fmt.sv
// L1D load response formatter: extracts/extends the result
// and queues it toward LSU/PTW with valid/ready.
module rvh_l1d_ld_resp_fmt
  import rvh_l1d_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    req_vld_i,
  output logic                    req_rdy_o,
  input  rrv64_l1d_req_type_dec_t req_type_i,
  input  logic [XLEN-1:0]         req_data_i,
  input  logic [2:0]              req_offset_i,
  input  logic                    req_sc_fail_i,
  input  logic [ROB_TAG_W-1:0]    req_rob_tag_i,
  input  logic [LDQ_TAG_W-1:0]    req_ldq_tag_i,
  output logic                    resp_vld_o,
  input  logic                    resp_rdy_i,
  output logic [XLEN-1:0]         resp_data_o,
  output logic [ROB_TAG_W-1:0]    resp_rob_tag_o,
  output logic [LDQ_TAG_W-1:0]    resp_ldq_tag_o,
  output logic                    resp_is_ptw_o,
  output logic                    resp_misalign_o
);

  rrv64_l1d_fmt_t        fmt;
  rrv64_l1d_resp_entry_t enq;
  rrv64_l1d_resp_entry_t head;
  logic                  enq_cls;

  // pure stores and empty types are consumed without a response
  assign enq_cls = req_type_i.is_ld  | req_type_i.is_ptw_ld |
                   req_type_i.is_lr  | req_type_i.is_sc |
                   req_type_i.is_amo;

  always_comb begin
    fmt = rrv64_l1d_ld_fmt(req_type_i, req_data_i, req_offset_i);
    enq = '0;
    enq.rob_tag  = req_rob_tag_i;
    enq.ldq_tag  = req_ldq_tag_i;
    enq.is_ptw   = req_type_i.is_ptw_ld;
    enq.misalign = fmt.misalign;
    enq.data     = fmt.data;
    if (req_type_i.is_sc && !fmt.misalign)
      enq.data = {{(XLEN-1){1'b0}}, req_sc_fail_i};
  end

  rvh_l1d_resp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_i),
    .push_vld  (req_vld_i & enq_cls),
    .push_rdy  (req_rdy_o),
    .push_data (enq),
    .pop_vld   (resp_vld_o),
    .pop_rdy   (resp_rdy_i),
    .pop_data  (head)
  );

  assign resp_data_o     = head.data;
  assign resp_rob_tag_o  = head.rob_tag;
  assign resp_ldq_tag_o  = head.ldq_tag;
  assign resp_is_ptw_o   = head.is_ptw;
  assign resp_misalign_o = head.misalign;

endmodule

// File: tb/tb_rvh_l1d_ld_resp_fmt.sv
// Bench for rvh_l1d_ld_resp_fmt: queue model plus
// directed vectors with literal expectations.
module tb_rvh_l1d_ld_resp_fmt;
  import rvh_l1d_pkg::*;

  localparam logic [10:0] T_LB   = 11'b100000_1000_0;
  localparam logic [10:0] T_LBU  = 11'b100000_1000_1;
  localparam logic [10:0] T_LH   = 11'b100000_0100_0;
  localparam logic [10:0] T_LW   = 11'b100000_0010_0;
  localparam logic [10:0] T_LWU  = 11'b100000_0010_1;
  localparam logic [10:0] T_LD   = 11'b100000_0001_0;
  localparam logic [10:0] T_SCD  = 11'b000010_0001_0;
  localparam logic [10:0] T_SD   = 11'b001000_0001_0;
  localparam logic [10:0] T_PTW  = 11'b010000_0001_0;
  localparam logic [10:0] T_AMOW = 11'b000001_0010_1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flush_i;
  logic                    req_vld_i;
  logic                    req_rdy_o;
  rrv64_l1d_req_type_dec_t req_type_i;
  logic [63:0]             req_data_i;
  logic [2:0]              req_offset_i;
  logic                    req_sc_fail_i;
  logic [6:0]              req_rob_tag_i;
  logic [4:0]              req_ldq_tag_i;
  logic                    resp_vld_o;
  logic                    resp_rdy_i;
  logic [63:0]             resp_data_o;
  logic [6:0]              resp_rob_tag_o;
  logic [4:0]              resp_ldq_tag_o;
  logic                    resp_is_ptw_o;
  logic                    resp_misalign_o;

  int checks   = 0;
  int failures = 0;

  rrv64_l1d_resp_entry_t q[$];
  bit m_pop;
  bit m_acc;

  rvh_l1d_ld_resp_fmt dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush_i),
    .req_vld_i       (req_vld_i),
    .req_rdy_o       (req_rdy_o),
    .req_type_i      (req_type_i),
    .req_data_i      (req_data_i),
    .req_offset_i    (req_offset_i),
    .req_sc_fail_i   (req_sc_fail_i),
    .req_rob_tag_i   (req_rob_tag_i),
    .req_ldq_tag_i   (req_ldq_tag_i),
    .resp_vld_o      (resp_vld_o),
    .resp_rdy_i      (resp_rdy_i),
    .resp_data_o     (resp_data_o),
    .resp_rob_tag_o  (resp_rob_tag_o),
    .resp_ldq_tag_o  (resp_ldq_tag_o),
    .resp_is_ptw_o   (resp_is_ptw_o),
    .resp_misalign_o (resp_misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Spec-level model: size in bytes, shift, mask, extend
  function automatic rrv64_l1d_resp_entry_t mdl(
    input rrv64_l1d_req_type_dec_t t, input logic [63:0] d,
    input int off, input logic scf,
    input logic [6:0] rob, input logic [4:0] ldq);
    rrv64_l1d_resp_entry_t e;
    int          n;
    logic [63:0] v;
    logic [63:0] m;
    bit          sgn;
    n = 8;
    if (!(t.op_dw || t.is_ptw_ld)) begin
      if (t.op_w)       n = 4;
      else if (t.op_hw) n = 2;
      else if (t.op_b)  n = 1;
    end
    e.misalign = ((off % n) != 0);
    v = d >> (off * 8);
    if (n < 8) begin
      m   = (64'd1 << (8 * n)) - 64'd1;
      v   = v & m;
      sgn = !t.ld_u || t.is_lr || t.is_amo || t.is_sc;
      if (sgn && v[8*n-1]) v = v | ~m;
    end
    if (t.is_sc) v = {63'b0, scf};
    if (e.misalign) v = '0;
    e.data    = v;
    e.rob_tag = rob;
    e.ldq_tag = ldq;
    e.is_ptw  = t.is_ptw_ld;
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst || flush_i) q.delete();
    else begin
      m_pop = (q.size() > 0) && resp_rdy_i;
      m_acc = req_vld_i && ((q.size() < 2) || m_pop);
      if (m_pop) void'(q.pop_front());
      if (m_acc && (req_type_i.is_ld || req_type_i.is_ptw_ld ||
          req_type_i.is_lr || req_type_i.is_sc || req_type_i.is_amo))
        q.push_back(mdl(req_type_i, req_data_i, int'(req_offset_i),
                        req_sc_fail_i, req_rob_tag_i, req_ldq_tag_i));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      chk("rst_vld", resp_vld_o, 0);
      chk("rst_data", resp_data_o, 0);
    end else begin
      chk("sb_vld", resp_vld_o, q.size() != 0);
      chk("sb_rdy", req_rdy_o,
          (q.size() < 2) || ((q.size() > 0) && resp_rdy_i));
      if (q.size() > 0) begin
        chk("sb_data", resp_data_o, q[0].data);
        chk("sb_rob", resp_rob_tag_o, q[0].rob_tag);
        chk("sb_ldq", resp_ldq_tag_o, q[0].ldq_tag);
        chk("sb_ptw", resp_is_ptw_o, q[0].is_ptw);
        chk("sb_mis", resp_misalign_o, q[0].misalign);
      end
    end
  end

  task automatic drive(input logic [10:0] t, input logic [63:0] d,
                       input logic [2:0] off, input logic scf,
                       input logic [6:0] rob, input logic [4:0] ldq);
    req_type_i    = rrv64_l1d_req_type_dec_t'(t);
    req_data_i    = d;
    req_offset_i  = off;
    req_sc_fail_i = scf;
    req_rob_tag_i = rob;
    req_ldq_tag_i = ldq;
    req_vld_i     = 1'b1;
  endtask

  task automatic issue(input logic [10:0] t, input logic [63:0] d,
                       input logic [2:0] off, input logic scf,
                       input logic [6:0] rob, input logic [4:0] ldq);
    drive(t, d, off, scf, rob, ldq);
    @(posedge clk);
    #1 req_vld_i = 1'b0;
  endtask

  task automatic issue_chk(input string nm, input logic [10:0] t,
                           input logic [63:0] d, input logic [2:0] off,
                           input logic scf, input logic [63:0] exp_d,
                           input logic exp_m);
    issue(t, d, off, scf, 7'd3, 5'd3);
    @(negedge clk);
    chk({nm, "_vld"}, resp_vld_o, 1);
    chk({nm, "_data"}, resp_data_o, exp_d);
    chk({nm, "_mis"}, resp_misalign_o, exp_m);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b0;
    flush_i    = 1'b0;
    req_vld_i  = 1'b0;
    resp_rdy_i = 1'b1;
    drive(T_LD, 64'd0, 3'd0, 1'b0, 7'd0, 5'd0);
    req_vld_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_rdy", req_rdy_o, 1);
    @(posedge clk);
    #1;

    issue_chk("lb", T_LB, 64'h0000_0000_80FF_0000, 3'd3, 1'b0,
              64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    issue_chk("lbu", T_LBU, 64'h0000_0000_80FF_0000, 3'd3, 1'b0,
              64'h0000_0000_0000_0080, 1'b0);
    issue_chk("lw", T_LW, 64'h8000_0001_1234_5678, 3'd4, 1'b0,
              64'hFFFF_FFFF_8000_0001, 1'b0);
    issue_chk("lwu", T_LWU, 64'h8000_0001_1234_5678, 3'd4, 1'b0,
              64'h0000_0000_8000_0001, 1'b0);
    issue_chk("sc_fail", T_SCD, 64'hDEAD_BEEF_0000_0000, 3'd0, 1'b1,
              64'd1, 1'b0);
    issue_chk("sc_ok", T_SCD, 64'hDEAD_BEEF_0000_0000, 3'd0, 1'b0,
              64'd0, 1'b0);
    issue_chk("lh_mis", T_LH, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0,
              64'd0, 1'b1);
    issue_chk("amow", T_AMOW, 64'hFFFF_FFFE_0000_0000, 3'd4, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    issue_chk("lh", T_LH, 64'h0000_7FFF_0000_0000, 3'd4, 1'b0,
              64'h0000_0000_0000_7FFF, 1'b0);
    issue_chk("ptw", T_PTW, 64'h0123_4567_89AB_CDEF, 3'd0, 1'b0,
              64'h0123_4567_89AB_CDEF, 1'b0);
    issue_chk("ld_mis", T_LD, 64'h0123_4567_89AB_CDEF, 3'd2, 1'b0,
              64'd0, 1'b1);

    issue(T_SD, 64'h1111_2222_3333_4444, 3'd0, 1'b0, 7'd5, 5'd5);
    @(negedge clk);
    chk("sd_novld", resp_vld_o, 0);
    @(posedge clk);
    #1;

    resp_rdy_i = 1'b0;
    issue(T_LD, 64'hA, 3'd0, 1'b0, 7'd10, 5'd1);
    issue(T_LD, 64'hB, 3'd0, 1'b0, 7'd11, 5'd2);
    drive(T_LD, 64'hC, 3'd0, 1'b0, 7'd12, 5'd3);
    @(negedge clk);
    chk("bp_rdy0", req_rdy_o, 0);
    chk("bp_head0", resp_rob_tag_o, 10);
    #1 resp_rdy_i = 1'b1;
    @(posedge clk);
    #1 req_vld_i = 1'b0;
    @(negedge clk);
    chk("bp_head1", resp_rob_tag_o, 11);
    chk("bp_ldq1", resp_ldq_tag_o, 2);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_head2", resp_rob_tag_o, 12);
    chk("bp_ldq2", resp_ldq_tag_o, 3);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_empty", resp_vld_o, 0);
    @(posedge clk);
    #1;

    resp_rdy_i = 1'b0;
    issue(T_LD, 64'h1, 3'd0, 1'b0, 7'd20, 5'd4);
    issue(T_LD, 64'h2, 3'd0, 1'b0, 7'd21, 5'd5);
    drive(T_LD, 64'h3, 3'd0, 1'b0, 7'd22, 5'd6);
    resp_rdy_i = 1'b1;
    flush_i    = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    req_vld_i  = 1'b0;
    @(negedge clk);
    chk("flush_vld", resp_vld_o, 0);
    @(posedge clk);
    #1;

    resp_rdy_i = 1'b0;
    issue(T_LW, 64'h8000_0000, 3'd0, 1'b0, 7'd30, 5'd7);
    rst = 1'b0;
    #1;
    chk("arst_vld", resp_vld_o, 0);
    chk("arst_data", resp_data_o, 0);
    chk("arst_rob", resp_rob_tag_o, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    resp_rdy_i = 1'b1;
    issue(T_LBU, 64'hFF, 3'd0, 1'b0, 7'd31, 5'd8);
    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
